shift_sequencer: RTL

Multi-cycle controller that sequences the 8-bit barrel shifters to execute shift and rotate requests with shift amounts wider than the shifters' 3-bit range. It sits between the ALU issue logic and the `barrelShifter_LSL`, `barrelShifter_LSR` and `barrelShifter_ASR` instances. It splits each request into steps of at most 7 bit positions and iterates over a working register. Results are returned through a valid/ready handshake.

---
 rtl/shift_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate controller built around three
// 8-bit barrel shifters with a 3-bit amount. Each request is split into
// steps of at most 7 positions applied to a working register, and the
// result is returned over a valid/ready response channel.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. REQ_READY is high only in IDLE, RESP_VALID only in DONE.
// RESP_DATA holds stable while RESP_VALID waits for RESP_READY.
//
// Optional feature macro: SHIFT_SEQ_CLAMP_EN. When it is defined, the
// amount is clamped to 8 for shifts and reduced mod 8 for rotates, so the
// latency is at most 2 steps. Results are identical in both builds.

module barrelShifter_LSL (
  input  logic [7:0] data_i,
  input  logic [2:0] amt_i,
  output logic [7:0] data_o
);
  assign data_o = data_i << amt_i;
endmodule

module barrelShifter_LSR (
  input  logic [7:0] data_i,
  input  logic [2:0] amt_i,
  output logic [7:0] data_o
);
  assign data_o = data_i >> amt_i;
endmodule

module barrelShifter_ASR (
  input  logic [7:0] data_i,
  input  logic [2:0] amt_i,
  output logic [7:0] data_o
);
  assign data_o = 8'($signed(data_i) >>> amt_i);
endmodule

module shift_sequencer #(
  parameter int AMOUNT_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [1:0]              REQ_OP,
  input  logic [7:0]              REQ_DATA,
  input  logic [AMOUNT_WIDTH-1:0] REQ_AMOUNT,
  output logic                    RESP_VALID,
  input  logic                    RESP_READY,
  output logic [7:0]              RESP_DATA,
  output logic                    RESP_ZERO,
  output logic                    BUSY,
  output logic [1:0]              DBG_STATE
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [7:0]              work_q, work_d;
  logic [AMOUNT_WIDTH-1:0] rem_q, rem_d;

  logic [AMOUNT_WIDTH-1:0] eff_amt;
  logic [AMOUNT_WIDTH-1:0] rem_next;
  logic [2:0]              step;
  logic [2:0]              lsl_amt;
  logic [7:0]              lsl_out, lsr_out, asr_out;
  logic [7:0]              step_result;
  logic [31:0]             req_amt32;
  logic [31:0]             rem32;

  // Effective amount latched on accept; the clamp only shortens iteration.
  always_comb begin
    req_amt32 = 32'(REQ_AMOUNT);
`ifdef SHIFT_SEQ_CLAMP_EN
    if (REQ_OP == 2'b11) begin
      eff_amt = AMOUNT_WIDTH'(req_amt32 & 32'd7);
    end else if (req_amt32 > 32'd8) begin
      eff_amt = AMOUNT_WIDTH'(32'd8);
    end else begin
      eff_amt = REQ_AMOUNT;
    end
`else
    eff_amt = REQ_AMOUNT;
`endif
  end

  // Step size for this cycle and the remaining distance after it.
  always_comb begin
    rem32    = 32'(rem_q);
    step     = (rem32 > 32'd7) ? 3'd7 : rem32[2:0];
    rem_next = AMOUNT_WIDTH'(rem32 - 32'(step));
    // Rotate uses the left shifter with 8-STEP; 3'(0-STEP) is that value
    // mod 8, and STEP=0 gives 0 so the rotate passes WORK through.
    lsl_amt  = (op_q == 2'b11) ? 3'(3'd0 - step) : step;
  end

  barrelShifter_LSL u_lsl (.data_i(work_q), .amt_i(lsl_amt), .data_o(lsl_out));
  barrelShifter_LSR u_lsr (.data_i(work_q), .amt_i(step),    .data_o(lsr_out));
  barrelShifter_ASR u_asr (.data_i(work_q), .amt_i(step),    .data_o(asr_out));

  // Select the step function for the latched operation.
  always_comb begin
    case (op_q)
      OP_LSL:  step_result = lsl_out;
      OP_LSR:  step_result = lsr_out;
      OP_ASR:  step_result = asr_out;
      default: step_result = lsr_out | lsl_out;
    endcase
  end

  // Next-state logic for the IDLE -> EXEC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          state_d = ST_EXEC;
          op_d    = REQ_OP;
          work_d  = REQ_DATA;
          rem_d   = eff_amt;
        end
      end
      ST_EXEC: begin
        work_d = step_result;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (RESP_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      work_q  <= 8'h00;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
    end
  end

  assign REQ_READY  = (state_q == ST_IDLE);
  assign RESP_VALID = (state_q == ST_DONE);
  assign RESP_DATA  = work_q;
  assign RESP_ZERO  = (state_q == ST_DONE) && (work_q == 8'h00);
  assign BUSY       = (state_q != ST_IDLE);
  assign DBG_STATE  = state_q;

endmodule
